// File: rtl/mul_wb_arbiter.sv
// mul_wb_arbiter
//   Merges the single-cycle ALU result stream and the multi-cycle MUL/DIV
//   result stream onto the single register-file write port.
//   - MUL results always win the write port. Their results are older than
//     any ALU result that arrives in the same cycle or later.
//   - An ALU result that cannot be written immediately waits in a small
//     circular FIFO. The FIFO drains in order whenever no MUL result is
//     present.
//   - Decode is stalled early enough to keep one FIFO slot free for a
//     result that is already in flight.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   alu_valid_i/_reg_write_i    ALU result strobe and its "writes rd" flag
//   alu_rd_i, alu_result_i      ALU destination register and data
//   mul_valid_i/_reg_write_i    MUL/DIV result strobe and its "writes rd" flag
//   mul_rd_i, mul_result_i      MUL/DIV destination register and data
//   stall_o                     upstream must hold off new ALU results
//   rf_we_o/_waddr_o/_wdata_o   registered register-file write port
//   count_o                     FIFO occupancy
//   overflow_o                  sticky: an ALU result was dropped
module mul_wb_arbiter #(
  parameter int DEPTH          = 4,
  parameter int INSTR_REG_SIZE = 5,
  parameter int WD_SIZE        = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid_i,
  input  logic                          alu_reg_write_i,
  input  logic [INSTR_REG_SIZE-1:0]     alu_rd_i,
  input  logic [WD_SIZE-1:0]            alu_result_i,
  input  logic                          mul_valid_i,
  input  logic                          mul_reg_write_i,
  input  logic [INSTR_REG_SIZE-1:0]     mul_rd_i,
  input  logic [WD_SIZE-1:0]            mul_result_i,
  output logic                          stall_o,
  output logic                          rf_we_o,
  output logic [INSTR_REG_SIZE-1:0]     rf_waddr_o,
  output logic [WD_SIZE-1:0]            rf_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // FIFO storage: no reset, so it can map onto distributed/block RAM.
  logic [INSTR_REG_SIZE-1:0] rd_mem   [DEPTH];
  logic [WD_SIZE-1:0]        data_mem [DEPTH];

  logic [PW-1:0]             head_reg, tail_reg;
  logic [CW-1:0]             count_reg, count_next;
  logic                      rf_we_reg;
  logic [INSTR_REG_SIZE-1:0] rf_waddr_reg;
  logic [WD_SIZE-1:0]        rf_wdata_reg;
  logic                      overflow_reg;

  logic alu_eff, mul_eff;
  logic fifo_empty, fifo_full;
  logic deq, enq, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign alu_eff = alu_valid_i & alu_reg_write_i & (alu_rd_i != '0);
  assign mul_eff = mul_valid_i & mul_reg_write_i & (mul_rd_i != '0);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));

  // The FIFO head owns the port whenever MUL is absent.
  assign deq = ~mul_eff & ~fifo_empty;
  // An ALU result is parked whenever something older holds the port this
  // cycle. At full, a same-cycle dequeue frees the slot it needs.
  assign enq  = alu_eff & (mul_eff | ~fifo_empty) & (~fifo_full | deq);
  assign drop = alu_eff & fifo_full & ~deq;

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (enq) tail_reg <= ptr_inc(tail_reg);
      if (deq) head_reg <= ptr_inc(head_reg);
      if (drop) overflow_reg <= 1'b1;

      // Address/data hold their last value on idle cycles.
      rf_we_reg <= mul_eff | deq | alu_eff;
      if (mul_eff) begin
        rf_waddr_reg <= mul_rd_i;
        rf_wdata_reg <= mul_result_i;
      end else if (deq) begin
        rf_waddr_reg <= rd_mem[head_reg];
        rf_wdata_reg <= data_mem[head_reg];
      end else if (alu_eff) begin
        rf_waddr_reg <= alu_rd_i;
        rf_wdata_reg <= alu_result_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[tail_reg]   <= alu_rd_i;
      data_mem[tail_reg] <= alu_result_i;
    end
  end

  // Stall one entry early: an ALU result may already be in flight when
  // decode sees the stall.
  assign stall_o    = (count_reg >= CW'(DEPTH - 1));
  assign rf_we_o    = rf_we_reg;
  assign rf_waddr_o = rf_waddr_reg;
  assign rf_wdata_o = rf_wdata_reg;
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_mul_wb_arbiter.sv
module tb_mul_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid_i = 1'b0, alu_reg_write_i = 1'b0;
  logic [RW-1:0] alu_rd_i = '0;
  logic [DW-1:0] alu_result_i = '0;
  logic          mul_valid_i = 1'b0, mul_reg_write_i = 1'b0;
  logic [RW-1:0] mul_rd_i = '0;
  logic [DW-1:0] mul_result_i = '0;
  logic          stall_o, rf_we_o, overflow_o;
  logic [RW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [2:0]    count_o;

  mul_wb_arbiter #(.DEPTH(DEPTH), .INSTR_REG_SIZE(RW), .WD_SIZE(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_reg_write_i(alu_reg_write_i),
    .alu_rd_i(alu_rd_i), .alu_result_i(alu_result_i),
    .mul_valid_i(mul_valid_i), .mul_reg_write_i(mul_reg_write_i),
    .mul_rd_i(mul_rd_i), .mul_result_i(mul_result_i),
    .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of parked ALU results and the expected port.
  logic [RW+DW-1:0] m_q[$];
  logic [RW+DW-1:0] m_e;
  logic             exp_we = 1'b0, exp_ovf = 1'b0;
  logic [RW-1:0]    exp_waddr = '0;
  logic [DW-1:0]    exp_wdata = '0;
  bit               a_eff, m_eff;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_ovf = 1'b0;
    end else begin
      a_eff = alu_valid_i && alu_reg_write_i && (alu_rd_i != 0);
      m_eff = mul_valid_i && mul_reg_write_i && (mul_rd_i != 0);
      exp_we = 1'b0;
      if (m_eff) begin
        exp_we = 1'b1; exp_waddr = mul_rd_i; exp_wdata = mul_result_i;
        if (a_eff) begin
          if (m_q.size() < DEPTH) m_q.push_back({alu_rd_i, alu_result_i});
          else exp_ovf = 1'b1;
        end
      end else if (m_q.size() != 0) begin
        m_e = m_q.pop_front();
        exp_we = 1'b1; {exp_waddr, exp_wdata} = m_e;
        if (a_eff) m_q.push_back({alu_rd_i, alu_result_i});
      end else if (a_eff) begin
        exp_we = 1'b1; exp_waddr = alu_rd_i; exp_wdata = alu_result_i;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rf_we", 32'(rf_we_o), 32'(exp_we));
      chk("rf_waddr", 32'(rf_waddr_o), 32'(exp_waddr));
      chk("rf_wdata", rf_wdata_o, exp_wdata);
      chk("count", 32'(count_o), 32'(m_q.size()));
      chk("stall", 32'(stall_o), 32'(m_q.size() >= DEPTH - 1));
      chk("overflow", 32'(overflow_o), 32'(exp_ovf));
    end
  end

  task automatic drive(input logic av, input logic aw, input logic [RW-1:0] ard,
                       input logic [DW-1:0] ares, input logic mv, input logic mw,
                       input logic [RW-1:0] mrd, input logic [DW-1:0] mres);
    @(negedge clk);
    alu_valid_i = av; alu_reg_write_i = aw; alu_rd_i = ard; alu_result_i = ares;
    mul_valid_i = mv; mul_reg_write_i = mw; mul_rd_i = mrd; mul_result_i = mres;
    $display("cycle t=%0t alu(v=%0b w=%0b rd=%0d d=%0h) mul(v=%0b w=%0b rd=%0d d=%0h)",
             $time, av, aw, ard, ares, mv, mw, mrd, mres);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Literal expectation on the registered port, checked after the edge.
  task automatic lit(input string name, input logic we, input logic [RW-1:0] a,
                     input logic [DW-1:0] d, input int cnt);
    chk({name, ".we"}, 32'(rf_we_o), 32'(we));
    if (we) begin
      chk({name, ".waddr"}, 32'(rf_waddr_o), 32'(a));
      chk({name, ".wdata"}, rf_wdata_o, d);
    end
    chk({name, ".count"}, 32'(count_o), 32'(cnt));
  endtask

  int mul_pct;
  bit illegal;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset.we", 32'(rf_we_o), 0);
    chk("reset.waddr", 32'(rf_waddr_o), 0);
    chk("reset.wdata", rf_wdata_o, 0);
    chk("reset.count", 32'(count_o), 0);
    chk("reset.stall", 32'(stall_o), 0);
    chk("reset.overflow", 32'(overflow_o), 0);

    // ALU bypass
    drive(1, 1, 5, 32'h11, 0, 0, 0, 0);
    idle(); lit("bypass", 1, 5, 32'h11, 0);

    // MUL wins, ALU parked then drained
    drive(1, 1, 4, 32'hBB, 1, 1, 3, 32'hAA);
    idle(); lit("park1", 1, 3, 32'hAA, 1);
    idle(); lit("park2", 1, 4, 32'hBB, 0);

    // WAW on same rd
    drive(1, 1, 7, 32'h2, 1, 1, 7, 32'h1);
    idle(); lit("waw1", 1, 7, 32'h1, 1);
    idle(); lit("waw2", 1, 7, 32'h2, 0);

    // Three back-to-back MULs with ALU each cycle; pointers wrap here
    drive(1, 1, 10, 32'hA0, 1, 1, 20, 32'hC0);
    drive(1, 1, 11, 32'hA1, 1, 1, 21, 32'hC1);
    drive(1, 1, 12, 32'hA2, 1, 1, 22, 32'hC2);
    idle(); lit("burst", 1, 22, 32'hC2, 3);
    chk("burst.stall", 32'(stall_o), 1);
    idle(); lit("drain1", 1, 10, 32'hA0, 2);
    idle(); lit("drain2", 1, 11, 32'hA1, 1);
    idle(); lit("drain3", 1, 12, 32'hA2, 0);
    chk("drain3.stall", 32'(stall_o), 0);

    // Non-effective inputs
    drive(1, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    drive(1, 0, 3, 32'hBEEF, 1, 0, 6, 32'h55);
    lit("rd0", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 32'h66);
    lit("nowrite", 0, 0, 0, 0);
    idle(); lit("mulrd0", 0, 0, 0, 0);

    // Overflow: 5 parked ALU results under continuous MUL
    for (int i = 0; i < 5; i++)
      drive(1, 1, RW'(9 + i), 32'(32'h100 + i), 1, 1, RW'(1 + i), 32'(32'h200 + i));
    idle(); lit("ovf", 1, 5, 32'h204, 4);
    chk("ovf.flag", 32'(overflow_o), 1);
    idle(); lit("ovf.drain", 1, 9, 32'h100, 3);
    chk("ovf.sticky", 32'(overflow_o), 1);

    // Reset mid-operation
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst2.we", 32'(rf_we_o), 0);
    chk("rst2.waddr", 32'(rf_waddr_o), 0);
    chk("rst2.wdata", rf_wdata_o, 0);
    chk("rst2.count", 32'(count_o), 0);
    chk("rst2.stall", 32'(stall_o), 0);
    chk("rst2.overflow", 32'(overflow_o), 0);
    idle(); lit("rst2.idle", 0, 0, 0, 0);

    // Randomized traffic against the model
    mul_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mul_pct = (c / 200 % 3 == 0) ? 20 : (c / 200 % 3 == 1) ? 60 : 92;
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      illegal = ($urandom_range(0, 15) == 0);
      alu_valid_i     = ($urandom_range(0, 3) != 0) && (illegal || !stall_o);
      alu_reg_write_i = ($urandom_range(0, 7) != 0);
      alu_rd_i        = RW'($urandom_range(0, 7));
      alu_result_i    = $urandom;
      mul_valid_i     = ($urandom_range(0, 99) < mul_pct);
      mul_reg_write_i = ($urandom_range(0, 7) != 0);
      mul_rd_i        = RW'($urandom_range(0, 7));
      mul_result_i    = $urandom;
      $display("cycle t=%0t rst=%0b alu(v=%0b w=%0b rd=%0d) mul(v=%0b w=%0b rd=%0d) count=%0d",
               $time, reset, alu_valid_i, alu_reg_write_i, alu_rd_i,
               mul_valid_i, mul_reg_write_i, mul_rd_i, count_o);
    end
    @(negedge clk); reset = 1'b0;
    repeat (8) idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
